// File: rtl/button_debouncer_multi.sv
// -----------------------------------------------------------------------------
// button_debouncer_multi
//
// This module debounces NUM_BTNS asynchronous, bouncy push-buttons in the sysclk
// domain. Each channel has the following stages:
//   polarity fix -> 2-flop synchronizer -> stability counter -> clean level
// The clean level is followed by registered press/release strobes. An optional
// hold-to-repeat strobe can also be generated. All outputs are active-high
// "pressed", whatever the pin polarity.
//
// Ports:
//   sysclk       system clock
//   reset_n      asynchronous active-low reset; every register clears to idle
//   btn_raw      physical button pins (asynchronous, bouncy)
//   btn_clean    debounced pressed level
//   btn_press    one-cycle strobe, issued with a clean 0->1 change
//   btn_release  one-cycle strobe, issued with a clean 1->0 change
//   btn_repeat   one-cycle auto-repeat strobe while held (0 when REPEAT_EN=0)
//   any_pressed  registered OR of btn_clean (one cycle behind it)
// -----------------------------------------------------------------------------
module button_debouncer_multi #(
    parameter int NUM_BTNS      = 4,
    parameter int TIME_DELAY    = 500000,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                sysclk,
    input  logic                reset_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_clean,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_repeat,
    output logic                any_pressed
);

    localparam int CW = $clog2(TIME_DELAY + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIME_DELAY - 1);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    // Inverting before the synchronizer means reset (all zeros) always reads
    // as "not pressed", whatever the pin polarity.
    localparam logic [NUM_BTNS-1:0] POL = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_BTNS-1:0] sync1;
    logic [NUM_BTNS-1:0] sync2;
    logic [NUM_BTNS-1:0] cand;
    logic [CW-1:0]       cnt [NUM_BTNS];
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] fall;

    // Two-flop synchronizer, one per channel.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw ^ POL;
            sync2 <= sync1;
        end
    end

    // A candidate that has been stable long enough, and differs from the clean
    // level, commits this cycle. rise and fall are mutually exclusive.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if ((sync2[i] == cand[i]) && (cnt[i] == CNT_MAX)) begin
                rise[i] = cand[i] & ~btn_clean[i];
                fall[i] = ~cand[i] & btn_clean[i];
            end
        end
    end

    // Stability counter: it restarts whenever the synchronized input moves
    // away from the candidate, and saturates at CNT_MAX.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cand <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (sync2[i] != cand[i]) begin
                    cand[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // The clean level and its strobes update on the same edge.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            btn_clean   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            any_pressed <= 1'b0;
        end else begin
            btn_clean   <= (btn_clean | rise) & ~fall;
            btn_press   <= rise;
            btn_release <= fall;
            any_pressed <= |btn_clean;
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);

            logic [RW-1:0]       rcnt [NUM_BTNS];
            // Set after the first repeat, so the shorter period then applies.
            logic [NUM_BTNS-1:0] rphase;

            // The counter is cleared on the press edge. Because the counter is
            // zero-based, a match with the limit lands exactly REPEAT_DELAY
            // (or REPEAT_PERIOD) cycles after the previous event. A release
            // edge clears the counter before it can match, which keeps the
            // release cycle free of repeats.
            always_ff @(posedge sysclk or negedge reset_n) begin
                if (!reset_n) begin
                    btn_repeat <= '0;
                    rphase     <= '0;
                    for (int i = 0; i < NUM_BTNS; i++) begin
                        rcnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < NUM_BTNS; i++) begin
                        btn_repeat[i] <= 1'b0;
                        if (rise[i] || fall[i] || !btn_clean[i]) begin
                            rcnt[i]   <= '0;
                            rphase[i] <= 1'b0;
                        end else if (rcnt[i] == (rphase[i] ? RP_MAX : RD_MAX)) begin
                            btn_repeat[i] <= 1'b1;
                            rcnt[i]       <= '0;
                            rphase[i]     <= 1'b1;
                        end else begin
                            rcnt[i] <= rcnt[i] + RW'(1);
                        end
                    end
                end
            end
        end else begin : g_no_repeat
            assign btn_repeat = '0;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer_multi.sv
// -----------------------------------------------------------------------------
// Bench for button_debouncer_multi. There are two instances:
//   dut_a  ACTIVE_LOW=0
//   dut_b  ACTIVE_LOW=1
// They share the clock and reset. The reference model treats the two
// instances as eight channels. For each channel it keeps the following:
//   - the last TIME_DELAY+1 synchronized samples, used for the stability rule
//   - the edge index of the last press, so repeats follow from arithmetic
// -----------------------------------------------------------------------------
module tb_button_debouncer_multi;

    localparam int NB = 4;
    localparam int TD = 8;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int MC = 2 * NB;

    // ---------------- clock / reset ----------------
    logic sysclk  = 1'b0;
    logic reset_n = 1'b0;
    always #5 sysclk = ~sysclk;

    logic [NB-1:0] raw_a, raw_b;
    logic [NB-1:0] clean_a, press_a, rel_a, rep_a;
    logic [NB-1:0] clean_b, press_b, rel_b, rep_b;
    logic          any_a, any_b;

    button_debouncer_multi #(
        .NUM_BTNS(NB), .TIME_DELAY(TD), .ACTIVE_LOW(0), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_a (
        .sysclk(sysclk), .reset_n(reset_n), .btn_raw(raw_a),
        .btn_clean(clean_a), .btn_press(press_a), .btn_release(rel_a),
        .btn_repeat(rep_a), .any_pressed(any_a)
    );

    button_debouncer_multi #(
        .NUM_BTNS(NB), .TIME_DELAY(TD), .ACTIVE_LOW(1), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_b (
        .sysclk(sysclk), .reset_n(reset_n), .btn_raw(raw_b),
        .btn_clean(clean_b), .btn_press(press_b), .btn_release(rel_b),
        .btn_repeat(rep_b), .any_pressed(any_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit pipe0 [MC];
    bit pipe1 [MC];
    bit win   [MC][TD+1];
    bit m_clean [MC];
    bit m_press [MC];
    bit m_rel   [MC];
    bit m_rep   [MC];
    int press_edge [MC];
    bit m_any_a, m_any_b;
    int edge_no;

    function automatic bit pin_of(input int c);
        if (c < NB) return raw_a[c];
        else        return ~raw_b[c-NB];
    endfunction

    task automatic model_reset();
        edge_no = 0;
        m_any_a = 0;
        m_any_b = 0;
        for (int c = 0; c < MC; c++) begin
            pipe0[c] = 0; pipe1[c] = 0;
            m_clean[c] = 0; m_press[c] = 0; m_rel[c] = 0; m_rep[c] = 0;
            press_edge[c] = 0;
            for (int k = 0; k <= TD; k++) win[c][k] = 0;
        end
    endtask

    task automatic model_edge();
        bit seen, all1, all0, old_c, new_c;
        int d;
        edge_no++;
        m_any_a = 0;
        m_any_b = 0;
        for (int c = 0; c < NB; c++) begin
            m_any_a |= m_clean[c];
            m_any_b |= m_clean[c+NB];
        end
        for (int c = 0; c < MC; c++) begin
            seen     = pipe1[c];
            pipe1[c] = pipe0[c];
            pipe0[c] = pin_of(c);
            for (int k = 0; k < TD; k++) win[c][k] = win[c][k+1];
            win[c][TD] = seen;
            all1 = 1; all0 = 1;
            for (int k = 0; k <= TD; k++) begin
                if (win[c][k]) all0 = 0; else all1 = 0;
            end
            old_c = m_clean[c];
            new_c = all1 ? 1'b1 : (all0 ? 1'b0 : old_c);
            m_press[c] = new_c & ~old_c;
            m_rel[c]   = old_c & ~new_c;
            if (m_press[c]) press_edge[c] = edge_no;
            d = edge_no - press_edge[c];
            m_rep[c] = old_c && new_c && (d >= RD) && (((d - RD) % RP) == 0);
            m_clean[c] = new_c;
        end
    endtask

    task automatic compare_all();
        logic [NB-1:0] ec_a, ep_a, er_a, et_a, ec_b, ep_b, er_b, et_b;
        for (int c = 0; c < NB; c++) begin
            ec_a[c] = m_clean[c];    ep_a[c] = m_press[c];
            er_a[c] = m_rel[c];      et_a[c] = m_rep[c];
            ec_b[c] = m_clean[c+NB]; ep_b[c] = m_press[c+NB];
            er_b[c] = m_rel[c+NB];   et_b[c] = m_rep[c+NB];
        end
        check("clean_a",   32'(clean_a), 32'(ec_a));
        check("press_a",   32'(press_a), 32'(ep_a));
        check("release_a", 32'(rel_a),   32'(er_a));
        check("repeat_a",  32'(rep_a),   32'(et_a));
        check("any_a",     32'(any_a),   32'(m_any_a));
        check("clean_b",   32'(clean_b), 32'(ec_b));
        check("press_b",   32'(press_b), 32'(ep_b));
        check("release_b", 32'(rel_b),   32'(er_b));
        check("repeat_b",  32'(rep_b),   32'(et_b));
        check("any_b",     32'(any_b),   32'(m_any_b));
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge, and outputs are sampled
    // at the same point. Both are therefore well away from the active edge.
    task automatic step();
        @(posedge sysclk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({clean_a, press_a, rel_a, rep_a, clean_b, press_b, rel_b, rep_b,
                        any_a, any_b}), 32'h0);
    endtask

    int first, n_press, n_rel, n_rep, first_rep, second_rep, rep_after_rel, rel_edge;
    int hold [MC];

    initial begin
        raw_a = '0;
        raw_b = '1;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge sysclk);
        #1;
        check_all_zero("reset_state");
        reset_n = 1'b1;

        // Idle after reset, with the active-low pins high. Nothing may rise.
        repeat (12) step();
        check("al_idle_clean_b", 32'(clean_b), 32'h0);

        // Clean press on channel 0.
        raw_a[0] = 1'b1;
        first = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (press_a[0] && first == 0) first = i;
            if (i == 11) check("any_lag_low", 32'(any_a), 32'h0);
            if (i == 12) check("any_lag_high", 32'(any_a), 32'h1);
        end
        check("press0_edge", 32'(first), 32'd11);
        raw_a[0] = 1'b0;
        repeat (15) step();

        // Bounce on channel 1.
        n_press = 0; n_rel = 0; first = 0;
        raw_a[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); n_press += press_a[1]; n_rel += rel_a[1]; end
        raw_a[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); n_press += press_a[1]; n_rel += rel_a[1]; end
        raw_a[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_press += press_a[1];
            n_rel   += rel_a[1];
            if (press_a[1] && first == 0) first = i;
        end
        check("bounce_presses", 32'(n_press), 32'd1);
        check("bounce_releases", 32'(n_rel), 32'd0);
        check("bounce_press_edge", 32'(first), 32'd11);
        raw_a[1] = 1'b0;
        repeat (15) step();

        // Short glitch on channel 2. It is high for 8 cycles, so it never qualifies.
        n_press = 0; n_rel = 0; first = 0;
        raw_a[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin step(); n_press += press_a[2]; first |= clean_a[2]; end
        raw_a[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_press += press_a[2]; n_rel += rel_a[2]; first |= clean_a[2];
        end
        check("glitch_presses", 32'(n_press), 32'd0);
        check("glitch_releases", 32'(n_rel), 32'd0);
        check("glitch_clean", 32'(first), 32'd0);

        // Auto-repeat on channel 3. The pin is held for 60 cycles, which gives
        // a press at edge 11, repeats at 31, 36 ... 66 and a release at 71.
        first = 0; first_rep = 0; second_rep = 0; n_rep = 0; n_rel = 0;
        rep_after_rel = 0; rel_edge = 0;
        raw_a[3] = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 61) raw_a[3] = 1'b0;
            step();
            if (press_a[3] && first == 0) first = i;
            if (rel_a[3]) begin n_rel++; if (rel_edge == 0) rel_edge = i; end
            if (rep_a[3]) begin
                n_rep++;
                if (first_rep == 0) first_rep = i;
                else if (second_rep == 0) second_rep = i;
                if (rel_edge != 0) rep_after_rel++;
            end
        end
        check("rep_first_delay", 32'(first_rep - first), 32'd20);
        check("rep_period", 32'(second_rep - first_rep), 32'd5);
        check("rep_count", 32'(n_rep), 32'd8);
        check("rep_release_count", 32'(n_rel), 32'd1);
        check("rep_after_release", 32'(rep_after_rel), 32'd0);

        // Asynchronous reset while channel 0 is held and clean.
        raw_a[0] = 1'b1;
        repeat (14) step();
        check("pre_reset_clean0", 32'(clean_a[0]), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge sysclk);
        #1;
        check_all_zero("reset_hold");
        reset_n = 1'b1;
        #1;
        check_all_zero("reset_release");
        first = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (press_a[0] && first == 0) first = i;
        end
        check("press_after_reset", 32'(first), 32'd11);
        raw_a[0] = 1'b0;
        repeat (15) step();

        // Active-low instance, channel 0: pin 1->0.
        raw_b[0] = 1'b0;
        first = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (press_b[0] && first == 0) first = i;
        end
        check("al_press_edge", 32'(first), 32'd11);
        raw_b[0] = 1'b1;
        repeat (15) step();

        // Random stimulus on all channels, mixing glitches and long holds.
        for (int c = 0; c < MC; c++) hold[c] = $urandom_range(1, 20);
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < MC; c++) begin
                if (hold[c] == 0) begin
                    if (c < NB) raw_a[c] = ~raw_a[c];
                    else        raw_b[c-NB] = ~raw_b[c-NB];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(25, 70)
                                                          : $urandom_range(1, 12);
                end else begin
                    hold[c]--;
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
